ila_command_sequencer: RTL and testbench
========================================

# ila_command_sequencer

Byte-level command controller between the host receive path (UART/SPI byte receiver) and the ILA capture core. Decodes opcode bytes, collects multi-byte trigger configuration payloads, and issues hold/release/start/readout controls to the capture logic. Includes a per-payload inter-byte timeout so that a truncated command cannot lock the receive path. Replaces scattered single-opcode matchers with one sequenced decoder.

## Interface
- CFG_BYTES, 4: payload bytes following OP_SET_TRIG (1..16); o_cfg width = 8*CFG_BYTES.
- TIMEOUT_CYCLES, 1_000_000: max idle cycles between payload bytes; counter width = $clog2(TIMEOUT_CYCLES+1).
- i_clk  in  1  sole clock; all state rises on posedge.
- i_reset  in  1  asynchronous, active-low reset.
- i_ready_read  in  1  one-cycle strobe: i_Byte valid this cycle.
- i_Byte  in  8  received byte.
- i_read_done  in  1  readout engine finished (level or pulse, sampled each cycle).
- o_hold  out  1  sticky capture hold.
- o_start  out  1  one-cycle capture start pulse.
- o_cfg  out  8*CFG_BYTES  trigger configuration; first payload byte lands in o_cfg[7:0].
- o_cfg_valid  out  1  one-cycle pulse when o_cfg updated.
- o_read_req  out  1  one-cycle readout request pulse.
- o_busy  out  1  high in any state except IDLE.
- o_err  out  1  one-cycle error pulse.

## Operation
- Opcodes (exact byte match): OP_HOLD 0x11, OP_RELEASE 0x22, OP_START 0x33, OP_SET_TRIG 0x44, OP_READ 0x55.
- States: IDLE, PAYLOAD, COMMIT, WAIT_DONE.
- IDLE, strobe with byte: 0x11 -> o_hold<=1; 0x22 -> o_hold<=0; 0x33 -> o_start pulse (o_hold unchanged); 0x44 -> PAYLOAD, byte index<=0, timeout counter<=0; 0x55 -> o_read_req pulse, WAIT_DONE; any other value -> o_err pulse, stay IDLE.
- PAYLOAD: each strobe writes byte into shadow register slot [index], index++, counter<=0; after byte CFG_BYTES-1 -> COMMIT. Without strobe counter++; counter reaching TIMEOUT_CYCLES -> o_err pulse, IDLE, shadow discarded, o_cfg unchanged.
- COMMIT (one cycle): o_cfg<=shadow, o_cfg_valid pulse, -> IDLE. A strobe arriving during COMMIT is dropped and flags o_err.
- WAIT_DONE: i_read_done high -> IDLE. Strobes here are dropped, each flags o_err; o_hold unaffected.
- Payload bytes are raw data: opcode values inside a payload are not decoded.
- o_err, o_start, o_cfg_valid, o_read_req never exceed one cycle per event.

## Timing
- Reset (async assert, release synchronous to i_clk): state IDLE, all outputs 0, o_cfg all zeros, shadow/index/counter 0.
- Single-byte opcodes: strobe at edge n -> output effect visible after edge n+1 (1-cycle registered latency).
- OP_SET_TRIG: last payload strobe at edge n -> COMMIT at n+1 -> o_cfg and o_cfg_valid valid after n+2; o_busy falls at n+2.
- OP_READ: o_read_req high for cycle following opcode; i_read_done sampled from the next cycle on (done coincident with req is ignored); IDLE one cycle after done seen.
- Timeout: error pulse on the cycle the counter equals TIMEOUT_CYCLES; back-to-back strobes every cycle supported in IDLE and PAYLOAD.
- Reset asserted mid-PAYLOAD or mid-WAIT_DONE: immediate return to IDLE, partial payload lost, o_cfg cleared.

## Structure
- Package ila_cmd_pkg: OP_* opcode constants, state enum encoding, CFG_BYTES default.
- Sub-module ila_cmd_timeout: resettable up-counter with clear/enable inputs and terminal-count output, parameterised by TIMEOUT_CYCLES.
- Top holds FSM, shadow register, index, output registers.

## Test plan
- Reset then 0x11, later 0x22 -> o_hold 1 one cycle after first strobe, 0 one cycle after second; all pulses stay 0.
- 0x44, AA, BB, CC, DD (CFG_BYTES=4) -> o_cfg=0xDDCCBBAA with single o_cfg_valid pulse two cycles after DD strobe; o_busy high from opcode to commit.
- 0x44, AA, BB then idle with TIMEOUT_CYCLES=16 -> one o_err pulse 16 cycles after BB, o_cfg keeps previous value, state IDLE.
- 0x55, then 0x33 strobe before i_read_done -> one o_read_req pulse, o_err for 0x33, no o_start; after i_read_done, 0x33 -> o_start pulse.
- Byte 0x7F in IDLE -> one o_err pulse, no other output changes; payload 0x11 inside SET_TRIG -> stored, o_hold unchanged.
- Assert i_reset mid-payload after two bytes -> all outputs 0 asynchronously; subsequent full SET_TRIG loads cleanly.

Source files
------------

// File: rtl/ila_cmd_pkg.sv
// Shared opcode values, FSM state encoding and default sizing for the ILA command sequencer.
package ila_cmd_pkg;

  localparam logic [7:0] OP_HOLD     = 8'h11;
  localparam logic [7:0] OP_RELEASE  = 8'h22;
  localparam logic [7:0] OP_START    = 8'h33;
  localparam logic [7:0] OP_SET_TRIG = 8'h44;
  localparam logic [7:0] OP_READ     = 8'h55;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PAYLOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT    = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int CFG_BYTES_DEFAULT      = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/ila_cmd_timeout.sv
// Inter-byte idle counter; tc_o fires on the enabled cycle whose edge brings the count to TIMEOUT_CYCLES.
module ila_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Saturates at the limit so tc_o can only fire once per idle stretch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/ila_command_sequencer.sv
// Host byte-stream decoder driving the ILA capture core: opcodes, trigger payload collection,
// readout handshake and inter-byte timeout.
module ila_command_sequencer
  import ila_cmd_pkg::*;
#(
  parameter int CFG_BYTES      = CFG_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_ready_read,
  input  logic [7:0]             i_Byte,
  input  logic                   i_read_done,
  output logic                   o_hold,
  output logic                   o_start,
  output logic [8*CFG_BYTES-1:0] o_cfg,
  output logic                   o_cfg_valid,
  output logic                   o_read_req,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int IDX_W = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CFG_BYTES - 1);

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [8*CFG_BYTES-1:0] shadow_q, shadow_d;
  logic [8*CFG_BYTES-1:0] cfg_q, cfg_d;
  logic hold_q, hold_d;
  logic start_q, start_d;
  logic cfg_valid_q, cfg_valid_d;
  logic read_req_q, read_req_d;
  logic err_q, err_d;
  logic tmo_clr, tmo_en, tmo_tc;

  assign tmo_en  = (state_q == ST_PAYLOAD);
  assign tmo_clr = !tmo_en || i_ready_read;

  ila_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (i_clk),
    .rst_ni(i_reset),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    hold_d      = hold_q;
    start_d     = 1'b0;
    cfg_valid_d = 1'b0;
    read_req_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_ready_read) begin
          case (i_Byte)
            OP_HOLD:    hold_d = 1'b1;
            OP_RELEASE: hold_d = 1'b0;
            OP_START:   start_d = 1'b1;
            OP_SET_TRIG: begin
              state_d  = ST_PAYLOAD;
              idx_d    = '0;
              shadow_d = '0;
            end
            OP_READ: begin
              read_req_d = 1'b1;
              state_d    = ST_WAIT_DONE;
            end
            default:    err_d = 1'b1;
          endcase
        end
      end

      // Payload bytes are stored verbatim; a byte arriving on the timeout cycle still counts.
      ST_PAYLOAD: begin
        if (i_ready_read) begin
          for (int b = 0; b < CFG_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
              shadow_d[b*8 +: 8] = i_Byte;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_COMMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (tmo_tc) begin
          err_d    = 1'b1;
          state_d  = ST_IDLE;
          idx_d    = '0;
          shadow_d = '0;
        end
      end

      ST_COMMIT: begin
        cfg_d       = shadow_q;
        cfg_valid_d = 1'b1;
        state_d     = ST_IDLE;
        err_d       = i_ready_read;
      end

      // A done seen while the request pulse is still out belongs to a previous readout.
      ST_WAIT_DONE: begin
        err_d = i_ready_read;
        if (i_read_done && !read_req_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      hold_q      <= 1'b0;
      start_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      read_req_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      hold_q      <= hold_d;
      start_q     <= start_d;
      cfg_valid_q <= cfg_valid_d;
      read_req_q  <= read_req_d;
      err_q       <= err_d;
    end
  end

  assign o_hold      = hold_q;
  assign o_start     = start_q;
  assign o_cfg       = cfg_q;
  assign o_cfg_valid = cfg_valid_q;
  assign o_read_req  = read_req_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ila_command_sequencer.sv
// Directed scoreboard bench for ila_command_sequencer with a 4-byte payload and a 16-cycle timeout.
module tb_ila_command_sequencer;

  typedef struct {
    logic [5:0]  vec;
    logic [31:0] cfg;
    string       tag;
  } expT;

  logic        clk;
  logic        resetN;
  logic        readyRead;
  logic [7:0]  rxByte;
  logic        readDone;
  logic        hold;
  logic        start;
  logic [31:0] cfg;
  logic        cfgValid;
  logic        readReq;
  logic        busy;
  logic        err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] modelCfg = '0;
  expT         expQ[$];

  ila_command_sequencer #(
    .CFG_BYTES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (resetN),
    .i_ready_read(readyRead),
    .i_Byte      (rxByte),
    .i_read_done (readDone),
    .o_hold      (hold),
    .o_start     (start),
    .o_cfg       (cfg),
    .o_cfg_valid (cfgValid),
    .o_read_req  (readReq),
    .o_busy      (busy),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs expected flags as {busy, hold, start, cfgValid, readReq, err}.
  function automatic logic [5:0] pk(input logic b, input logic h, input logic s,
                                    input logic v, input logic r, input logic e);
    return {b, h, s, v, r, e};
  endfunction

  task automatic pushExpect(input logic [5:0] vec, input string tag);
    expT e;
    e.vec = vec;
    e.cfg = modelCfg;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    logic [5:0] obs;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = expQ.pop_front();
    obs = {busy, hold, start, cfgValid, readReq, err};
    total++;
    assert (obs === e.vec) else begin
      bad++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", e.tag, obs, e.vec);
    end
    total++;
    assert (cfg === e.cfg) else begin
      bad++;
      $error("[TB] FAIL %s cfg observed=%h expected=%h", e.tag, cfg, e.cfg);
    end
  endtask

  // One clock cycle of stimulus; outputs are checked 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic stb, input logic [7:0] b, input logic done,
                               input logic [5:0] expVec, input string tag);
    readyRead = stb;
    rxByte    = b;
    readDone  = done;
    pushExpect(expVec, tag);
    @(posedge clk);
    #1;
    readyRead = 1'b0;
    rxByte    = 8'h00;
    readDone  = 1'b0;
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN    = 1'b0;
    readyRead = 1'b0;
    rxByte    = 8'h00;
    readDone  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExpect(pk(0,0,0,0,0,0), "reset_state");
    checkOutput();
    resetN = 1'b1;

    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,0), "idle_after_reset");
    applyStimulus(1, 8'h11, 0, pk(0,1,0,0,0,0), "op_hold");
    applyStimulus(0, 8'h00, 0, pk(0,1,0,0,0,0), "hold_sticky");
    applyStimulus(1, 8'h22, 0, pk(0,0,0,0,0,0), "op_release");

    applyStimulus(1, 8'h44, 0, pk(1,0,0,0,0,0), "set_trig_op");
    applyStimulus(1, 8'hAA, 0, pk(1,0,0,0,0,0), "payload0");
    applyStimulus(1, 8'hBB, 0, pk(1,0,0,0,0,0), "payload1");
    applyStimulus(1, 8'hCC, 0, pk(1,0,0,0,0,0), "payload2");
    applyStimulus(1, 8'hDD, 0, pk(1,0,0,0,0,0), "payload3_commit_state");
    modelCfg = 32'hDDCCBBAA;
    applyStimulus(0, 8'h00, 0, pk(0,0,0,1,0,0), "commit");
    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,0), "after_commit");

    applyStimulus(1, 8'h44, 0, pk(1,0,0,0,0,0), "tmo_op");
    applyStimulus(1, 8'h12, 0, pk(1,0,0,0,0,0), "tmo_byte0");
    applyStimulus(1, 8'h34, 0, pk(1,0,0,0,0,0), "tmo_byte1");
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 8'h00, 0, pk(1,0,0,0,0,0), $sformatf("tmo_wait%0d", i));
    end
    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,1), "tmo_expire");
    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,0), "tmo_after");

    applyStimulus(1, 8'h55, 0, pk(1,0,0,0,1,0), "op_read");
    applyStimulus(1, 8'h33, 1, pk(1,0,0,0,0,1), "start_in_wait_done");
    applyStimulus(0, 8'h00, 0, pk(1,0,0,0,0,0), "still_waiting");
    applyStimulus(0, 8'h00, 1, pk(0,0,0,0,0,0), "read_done");
    applyStimulus(1, 8'h33, 0, pk(0,0,1,0,0,0), "op_start");
    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,0), "start_one_cycle");

    applyStimulus(1, 8'h11, 0, pk(0,1,0,0,0,0), "hold_again");
    applyStimulus(1, 8'h7F, 0, pk(0,1,0,0,0,1), "bad_opcode");
    applyStimulus(1, 8'h22, 0, pk(0,0,0,0,0,0), "release_again");

    applyStimulus(1, 8'h44, 0, pk(1,0,0,0,0,0), "raw_op");
    applyStimulus(1, 8'h11, 0, pk(1,0,0,0,0,0), "raw_hold_byte");
    applyStimulus(1, 8'h22, 0, pk(1,0,0,0,0,0), "raw_release_byte");
    applyStimulus(1, 8'h55, 0, pk(1,0,0,0,0,0), "raw_read_byte");
    applyStimulus(1, 8'h33, 0, pk(1,0,0,0,0,0), "raw_start_byte");
    modelCfg = 32'h33552211;
    applyStimulus(1, 8'h11, 0, pk(0,0,0,1,0,1), "strobe_in_commit");
    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,0), "commit_drop_idle");

    applyStimulus(1, 8'h11, 0, pk(0,1,0,0,0,0), "pre_reset_hold");
    applyStimulus(1, 8'h44, 0, pk(1,1,0,0,0,0), "pre_reset_op");
    applyStimulus(1, 8'hA1, 0, pk(1,1,0,0,0,0), "pre_reset_b0");
    applyStimulus(1, 8'hA2, 0, pk(1,1,0,0,0,0), "pre_reset_b1");
    modelCfg = 32'h0;
    pushExpect(pk(0,0,0,0,0,0), "async_reset");
    #3;
    resetN = 1'b0;
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    resetN = 1'b1;

    applyStimulus(1, 8'h44, 0, pk(1,0,0,0,0,0), "reload_op");
    applyStimulus(1, 8'h01, 0, pk(1,0,0,0,0,0), "reload_b0");
    applyStimulus(1, 8'h02, 0, pk(1,0,0,0,0,0), "reload_b1");
    applyStimulus(1, 8'h03, 0, pk(1,0,0,0,0,0), "reload_b2");
    applyStimulus(1, 8'h04, 0, pk(1,0,0,0,0,0), "reload_b3");
    modelCfg = 32'h04030201;
    applyStimulus(0, 8'h00, 0, pk(0,0,0,1,0,0), "reload_commit");
    applyStimulus(0, 8'h00, 0, pk(0,0,0,0,0,0), "reload_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
